// File: rtl/branch_pc_unit.sv
// ID-stage branch resolution and PC sequencing for a five-stage MIPS pipeline.
// Detects hazards on the early branch comparator operands, drives its operand
// forwarding selects, resolves beq/bne/j and owns the fetch PC register.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic [1:0]  id_br_type,
    input  logic        id_jump,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_jtarget,
    input  logic [31:0] id_pc_plus4,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        zero,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] pc,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        branch_taken
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;

    logic        is_beq_s;
    logic        is_bne_s;
    logic        is_branch_s;
    logic        ex_dep_s;
    logic        mem_dep_s;
    logic [1:0]  need_s;
    logic        stall_s;
    logic        taken_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] next_pc_s;

    // A stage writing a non-zero rd that matches either branch source.
    function automatic logic dep_hit(input logic wr, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
        return wr && (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

    // Forward select for one operand: MEM ALU result beats WB result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic m_wr, input logic m_rd_load,
                                           input logic [4:0] m_rd,
                                           input logic w_wr, input logic [4:0] w_rd);
        if (m_wr && !m_rd_load && (m_rd != 5'd0) && (m_rd == src)) begin
            return 2'b01;
        end else if (w_wr && (w_rd != 5'd0) && (w_rd == src)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard detection, stall requirement, forwarding selects and redirect target.
    always_comb begin
        is_beq_s    = (id_br_type == 2'b01);
        is_bne_s    = (id_br_type == 2'b10);
        is_branch_s = is_beq_s || is_bne_s;
        ex_dep_s    = dep_hit(ex_regwrite, ex_rd, id_rs, id_rt);
        mem_dep_s   = dep_hit(mem_regwrite, mem_rd, id_rs, id_rt);

        if (!is_branch_s) begin
            need_s = 2'd0;
        end else if (ex_dep_s && ex_memread) begin
            need_s = 2'd2;
        end else if ((ex_dep_s && !ex_memread) || (mem_dep_s && mem_memread)) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end

        fwd_a_sel = fwd_sel(id_rs, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
        fwd_b_sel = fwd_sel(id_rt, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);

        // WAIT always stalls; RUN stalls only when the branch still needs operands.
        stall_s = (state_r == WAIT) || (need_s != 2'd0);

        taken_s     = (is_beq_s && zero) || (is_bne_s && !zero) || id_jump;
        br_target_s = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};
        j_target_s  = {id_pc_plus4[31:28], id_jtarget, 2'b00};

        // Jump wins over a simultaneously flagged branch; low PC bits stay 00.
        if (!taken_s) begin
            next_pc_s = pc + 32'd4;
        end else if (id_jump) begin
            next_pc_s = j_target_s;
        end else begin
            next_pc_s = {br_target_s[31:2], 2'b00};
        end
    end

    // Pipeline control outputs: freeze, stall, or advance/redirect.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        branch_taken = 1'b0;
        if (hold) begin
            pc_write = 1'b0;
        end else if (stall_s) begin
            id_ex_bubble = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = taken_s;
            branch_taken = taken_s;
        end
    end

    // Stall FSM, stall counter and architectural PC; hold freezes all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
            pc      <= {RESET_PC[31:2], 2'b00};
        end else if (hold) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
            pc      <= pc;
        end else begin
            case (state_r)
                RUN: begin
                    if (need_s != 2'd0) begin
                        cnt_r   <= need_s - 2'd1;
                        state_r <= (need_s == 2'd2) ? WAIT : RUN;
                    end else begin
                        cnt_r <= 2'd0;
                        pc    <= next_pc_s;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 2'd1;
                    if (cnt_r <= 2'd1) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector scoreboard bench for branch_pc_unit.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [1:0]  id_br_type;
    logic        id_jump;
    logic [15:0] id_imm;
    logic [25:0] id_jtarget;
    logic [31:0] id_pc_plus4;
    logic [4:0]  id_rs, id_rt;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite, mem_memread;
    logic [4:0]  mem_rd;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic        zero;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] pc;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, branch_taken;

    branch_pc_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .id_br_type(id_br_type), .id_jump(id_jump), .id_imm(id_imm),
        .id_jtarget(id_jtarget), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .zero(zero),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc(pc),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, branch_taken, fwd_a[1:0], fwd_b[1:0]}
    localparam logic [8:0] C_RUN   = 9'b1_1_0_0_0_00_00;
    localparam logic [8:0] C_TAKEN = 9'b1_1_1_0_1_00_00;
    localparam logic [8:0] C_STALL = 9'b0_0_0_1_0_00_00;
    localparam logic [8:0] C_HOLD  = 9'b0_0_0_0_0_00_00;
    localparam logic [8:0] FA_MEM  = 9'b0_0_0_0_0_01_00;
    localparam logic [8:0] FA_WB   = 9'b0_0_0_0_0_10_00;
    localparam logic [8:0] FB_MEM  = 9'b0_0_0_0_0_00_01;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [8:0]  ctl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, branch_taken,
                   fwd_a_sel, fwd_b_sel};
            checks++;
            if (act !== e.ctl || pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got pc=%h ctl=%b, expected pc=%h ctl=%b",
                         e.name, pc, act, e.pc, e.ctl);
            end
        end
    end

    task automatic clr();
        hold = 1'b0; id_br_type = 2'b00; id_jump = 1'b0; id_imm = 16'h0000;
        id_jtarget = 26'h0; id_pc_plus4 = 32'h0; id_rs = 5'd0; id_rt = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; zero = 1'b0;
    endtask

    // Push expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [31:0] epc, input logic [8:0] ectl);
        exp_t e;
        e.name = nm; e.pc = epc; e.ctl = ectl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        @(posedge clk);
        #1;
        // Reset and release
        cyc("rst", 32'h0040_0000, C_RUN);
        rst_n = 1'b1;
        cyc("rel", 32'h0040_0000, C_RUN);
        cyc("inc", 32'h0040_0004, C_RUN);

        // beq taken, negative offset: 0x100 + (-2<<2) = 0xF8
        id_br_type = 2'b01; zero = 1'b1; id_pc_plus4 = 32'h0000_0100; id_imm = 16'hFFFE;
        cyc("beq_t", 32'h0040_0008, C_TAKEN);
        clr();
        cyc("after_beq", 32'h0000_00F8, C_RUN);

        // bne not taken, then taken to 0x200 + 0x10
        id_br_type = 2'b10; zero = 1'b1; id_pc_plus4 = 32'h0000_0200; id_imm = 16'h0004;
        cyc("bne_nt", 32'h0000_00FC, C_RUN);
        zero = 1'b0;
        cyc("bne_t", 32'h0000_0100, C_TAKEN);

        // Load-use on rs=5: two stalls, then resolve forwarding from WB
        clr();
        id_br_type = 2'b01; zero = 1'b1; id_pc_plus4 = 32'h0000_0300; id_imm = 16'h0001;
        id_rs = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        cyc("ld_st1", 32'h0000_0210, C_STALL);
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd5;
        cyc("ld_st2", 32'h0000_0210, C_STALL);
        mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
        wb_regwrite = 1'b1; wb_rd = 5'd5;
        cyc("ld_res", 32'h0000_0210, C_TAKEN | FA_WB);

        // EX ALU dependency on rt=8: one stall, then forward from MEM (beq not taken)
        clr();
        id_br_type = 2'b01; zero = 1'b0; id_rt = 5'd8;
        ex_regwrite = 1'b1; ex_rd = 5'd8;
        cyc("alu_st", 32'h0000_0304, C_STALL);
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd8;
        cyc("alu_res", 32'h0000_0304, C_RUN | FB_MEM);

        // Register 0 never hazards or forwards
        clr();
        id_br_type = 2'b01; zero = 1'b1; id_pc_plus4 = 32'h0000_030C; id_imm = 16'h0002;
        ex_regwrite = 1'b1; ex_memread = 1'b1; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        cyc("rd0", 32'h0000_0308, C_TAKEN);

        // MEM beats WB; no stall when not a branch even with an EX load hit
        clr();
        id_rs = 5'd9; mem_regwrite = 1'b1; mem_rd = 5'd9; wb_regwrite = 1'b1; wb_rd = 5'd9;
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
        cyc("prio", 32'h0000_0314, C_RUN | FA_MEM);

        // Jump wins over a not-taken beq
        clr();
        id_jump = 1'b1; id_jtarget = 26'h000_0040; id_pc_plus4 = 32'hA000_0010;
        id_br_type = 2'b01; zero = 1'b0; id_imm = 16'h0010;
        cyc("jmp", 32'h0000_0318, C_TAKEN);

        // Hold mid-WAIT freezes FSM/cnt/pc; WAIT stall still owed afterwards
        clr();
        id_br_type = 2'b01; zero = 1'b1; id_pc_plus4 = 32'hA000_0104; id_imm = 16'h0000;
        id_rs = 5'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3;
        cyc("h_st1", 32'hA000_0100, C_STALL);
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        wb_regwrite = 1'b1; wb_rd = 5'd3; hold = 1'b1;
        cyc("h_hold1", 32'hA000_0100, C_HOLD | FA_WB);
        cyc("h_hold2", 32'hA000_0100, C_HOLD | FA_WB);
        hold = 1'b0;
        cyc("h_st2", 32'hA000_0100, C_STALL | FA_WB);
        cyc("h_res", 32'hA000_0100, C_TAKEN | FA_WB);

        // Reset mid-WAIT returns to RUN immediately
        clr();
        id_br_type = 2'b01; id_rs = 5'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3;
        cyc("r_st1", 32'hA000_0104, C_STALL);
        clr();
        rst_n = 1'b0;
        id_br_type = 2'b01; zero = 1'b0;
        cyc("r_rst", 32'h0040_0000, C_RUN);
        rst_n = 1'b1;
        cyc("r_run", 32'h0040_0000, C_RUN);
        cyc("r_inc", 32'h0040_0004, C_RUN);

        // PC wrap: jump to 0xFFFF_FFFC then sequential increment wraps to 0
        clr();
        id_jump = 1'b1; id_jtarget = 26'h3FF_FFFF; id_pc_plus4 = 32'hF000_0000;
        cyc("jwrap", 32'h0040_0008, C_TAKEN);
        clr();
        cyc("wrap", 32'hFFFF_FFFC, C_RUN);
        cyc("wrap0", 32'h0000_0000, C_RUN);

        for (int i = 0; i < 10; i++) begin
            if (q.size() != 0) @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- ID-stage branch resolution and PC sequencing for the five-stage MIPS pipeline.
- Detects data hazards on the early branch comparator's rs/rt operands, drives the comparator's operand forwarding selects, and consumes its equality flag.
- Resolves beq/bne/j and owns the architectural PC register, the IF/ID flush and the stall controls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  global pipeline freeze (e.g. memory wait)
id_br_type  in  2  00 none, 01 beq, 10 bne, 11 treated as none
id_jump  in  1  ID instruction is j
id_imm  in  16  branch offset, in words
id_jtarget  in  26  jump target field
id_pc_plus4  in  32  PC+4 of the ID instruction
id_rs, id_rt  in  5 each  branch source registers
ex_regwrite, ex_memread  in  1 each  EX-stage write / load flags
ex_rd  in  5  EX-stage destination
mem_regwrite, mem_memread  in  1 each  MEM-stage flags
mem_rd  in  5  MEM-stage destination
wb_regwrite  in  1  WB-stage write flag
wb_rd  in  5  WB-stage destination
zero  in  1  comparator flag; 1 when forwarded operands are equal
fwd_a_sel, fwd_b_sel  out  2 each  comparator operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
pc  out  32  current fetch PC (registered)
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  zero the IF/ID register next edge
id_ex_bubble  out  1  insert a NOP into ID/EX
branch_taken  out  1  redirect this cycle (branch taken or jump)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, FSM=RUN, stall counter=0.
  - Combinational outputs evaluate in RUN with no hazard.
  - Reset mid-stall aborts the stall immediately.
- Register 0 never creates a hazard or forward. A dependency exists when the stage's regwrite=1 and its rd equals id_rs or id_rt, with rd≠0.
- Stall requirement, evaluated only when id_br_type ∈ {01, 10}:
  - need=2 if EX is a load dependency.
  - Otherwise need=1 if EX is a non-load dependency or MEM is a load dependency.
  - Otherwise need=0.
- Forwarding, per operand:
  - MEM non-load dependency → 01.
  - Otherwise WB dependency → 10.
  - Otherwise 00.
  - MEM has priority over WB.
  - Selects are driven for every ID instruction regardless of stall.
- FSM states RUN, WAIT; 2-bit counter cnt.
  - RUN, need>0: stall this cycle; cnt←need−1; go to WAIT if need=2, else stay in RUN.
  - WAIT: stall this cycle; cnt←cnt−1; return to RUN when cnt reaches 0.
  - Net effect: a branch stalls exactly need cycles.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, branch_taken=0.
- Resolve, in RUN with need=0:
  - taken = (beq & zero) | (bne & ~zero) | id_jump.
  - Branch target = id_pc_plus4 + (sign_extend(id_imm)<<2), modulo 2^32.
  - Jump target = {id_pc_plus4[31:28], id_jtarget, 2'b00}.
  - id_jump takes priority if both id_jump and a branch are asserted.
- On taken:
  - pc←target, branch_taken=1, if_id_flush=1 for that single cycle, pc_write=1, if_id_write=1.
  - Total branch penalty: 1 flushed slot plus stall cycles.
- Not taken / no control instruction: pc←pc+4 (wraps 32'hFFFF_FFFC→0), pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
- hold=1:
  - FSM, cnt and pc freeze.
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, branch_taken=0.
  - Forward selects remain valid.
  - Resumes in the exact state when hold drops.
- pc[1:0] is always 00.

Test Plan:
1. Reset with rst_n=0 asynchronously, RESET_PC=32'h0040_0000 → pc=32'h0040_0000 with no clock edge required; the next edge after release gives pc=32'h0040_0004.
2. beq, no hazard, zero=1, id_pc_plus4=32'h100, id_imm=16'hFFFE → branch_taken=1, if_id_flush=1 for one cycle, next pc=32'h0F8.
3. bne with zero=1 → not taken, pc=pc+4, no flush; the same with zero=0 → taken.
4. beq with id_rs=5, EX load ex_rd=5 → two cycles of id_ex_bubble=1 with pc held, then resolve in the third cycle; on the resolve cycle fwd_a_sel=10 when WB carries rd=5.
5. EX ALU dependency on rt=8 → one stall, then fwd_b_sel=01; a dependency on rd=0 → no stall, selects=00.
6. id_jump with id_jtarget=26'h000_0040, id_pc_plus4=32'hA000_0010 → pc=32'hA000_0100; hold=1 asserted mid-WAIT freezes cnt and resumes correctly; rst_n dropped mid-WAIT returns the FSM to RUN.
